// File: rtl/hex_display_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hex_display_pkg
// Brief   : Shared FSM state type, segment constants and nibble encoder for
//           the hex/decimal seven-segment display controller.
// Revision: 1.0 - initial release
// ============================================================================
package hex_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    // Active-low segments, bit 7 is the decimal point and is held off.
    function automatic logic [7:0] nibble_to_seg(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

    // Decimal digits needed for a magnitude of up to 2^bits (log10(2) ~ 0.30103).
    function automatic int bcd_digits(input int bits);
        return (bits * 30103) / 100000 + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hex_display_ctrl_hexdriver.sv
`default_nettype none
// ============================================================================
// Module  : HexDriver
// Brief   : Combinational nibble to active-low seven-segment encoder (DP off).
// Revision: 1.0 - initial release
// ============================================================================
module HexDriver
    import hex_display_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [7:0] o_seg
);

    assign o_seg = nibble_to_seg(i_nibble);

endmodule
`default_nettype wire

// File: rtl/hex_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hex_display_ctrl
// Brief   : Loads a value, converts it to hex or signed decimal (sequential
//           double-dabble) and drives NUM_DIGITS seven-segment digits.
//           Optional blinking is enabled by defining HEX_DISPLAY_BLINK_EN.
// Revision: 1.0 - initial release
// ============================================================================
module hex_display_ctrl
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int DATA_W     = 16,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    load,
    input  logic [DATA_W-1:0]       data_in,
    input  logic                    mode,
    input  logic                    blank_lz,
    input  logic                    blink_en,
    output logic                    ready,
    output logic                    overflow,
    output logic [8*NUM_DIGITS-1:0] HEX_out
);

    localparam int c_bcd_raw = bcd_digits(DATA_W);
    localparam int c_bcd_n   = (c_bcd_raw > NUM_DIGITS - 1) ? c_bcd_raw : NUM_DIGITS - 1;
    localparam int c_cnt_w   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int c_pad_w   = (DATA_W > 4 * NUM_DIGITS) ? DATA_W : 4 * NUM_DIGITS;

    state_t                    r_state;
    logic [DATA_W-1:0]         r_data;
    logic [DATA_W-1:0]         r_bin;
    logic [4*c_bcd_n-1:0]      r_bcd;
    logic [c_cnt_w-1:0]        r_cnt;
    logic                      r_mode;
    logic                      r_blank_lz;
    logic                      r_sign;
    logic                      r_ready;
    logic                      r_overflow;
    logic [8*NUM_DIGITS-1:0]   r_hex;

    logic signed [DATA_W:0]    w_ext;
    logic [DATA_W:0]           w_mag;
    logic [4*c_bcd_n-1:0]      w_bcd_adj;
    logic [c_pad_w-1:0]        w_pad;
    logic [3:0]                w_nib [NUM_DIGITS];
    logic [7:0]                w_seg [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]     w_nz;
    logic [NUM_DIGITS-1:0]     w_lz_blank;
    logic [8*NUM_DIGITS-1:0]   w_hex_next;
    logic                      w_ovf;
    logic                      w_unused;

    // One extra bit so the most negative input negates without wrapping.
    assign w_ext    = {data_in[DATA_W-1], data_in};
    assign w_mag    = data_in[DATA_W-1] ? $unsigned(-w_ext) : $unsigned(w_ext);
    assign w_unused = w_mag[DATA_W];
    assign w_pad    = c_pad_w'(r_data);

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int d = 0; d < c_bcd_n; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) begin
                w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    generate
        if (c_bcd_n > NUM_DIGITS - 1) begin : g_ovf
            assign w_ovf = r_mode & (|r_bcd[4*c_bcd_n-1 : 4*(NUM_DIGITS-1)]);
        end else begin : g_no_ovf
            assign w_ovf = 1'b0;
        end
    endgenerate

    // A digit is a leading zero when it and every digit above it is zero.
    always_comb begin
        logic l_seen;
        l_seen     = 1'b0;
        w_lz_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            l_seen        = l_seen | w_nz[i];
            w_lz_blank[i] = r_blank_lz & ~l_seen & (i != 0);
        end
    end

    generate
        for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
            if (i < NUM_DIGITS - 1) begin : g_low
                assign w_nib[i] = r_mode ? r_bcd[4*i +: 4] : w_pad[4*i +: 4];
                assign w_hex_next[8*i +: 8] = w_ovf         ? SEG_DASH  :
                                              w_lz_blank[i] ? SEG_BLANK : w_seg[i];
            end else begin : g_top
                assign w_nib[i] = r_mode ? 4'd0 : w_pad[4*i +: 4];
                assign w_hex_next[8*i +: 8] = w_ovf         ? SEG_DASH  :
                                              r_mode        ? (r_sign ? SEG_DASH : SEG_BLANK) :
                                              w_lz_blank[i] ? SEG_BLANK : w_seg[i];
            end
            assign w_nz[i] = |w_nib[i];

            HexDriver u_hex_driver (
                .i_nibble (w_nib[i]),
                .o_seg    (w_seg[i])
            );
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= ST_IDLE;
            r_ready    <= 1'b1;
            r_overflow <= 1'b0;
            r_hex      <= '1;
            r_data     <= '0;
            r_bin      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_mode     <= 1'b0;
            r_blank_lz <= 1'b0;
            r_sign     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (load) begin
                        r_data     <= data_in;
                        r_mode     <= mode;
                        r_blank_lz <= blank_lz;
                        r_sign     <= mode & data_in[DATA_W-1];
                        r_bin      <= w_mag[DATA_W-1:0];
                        r_bcd      <= '0;
                        r_cnt      <= '0;
                        r_ready    <= 1'b0;
                        r_state    <= mode ? ST_SHIFT : ST_DONE;
                    end
                end
                ST_SHIFT: begin
                    r_bcd <= {w_bcd_adj[4*c_bcd_n-2:0], r_bin[DATA_W-1]};
                    r_bin <= {r_bin[DATA_W-2:0], 1'b0};
                    if (r_cnt == c_cnt_w'(DATA_W - 1)) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_hex      <= w_hex_next;
                    r_overflow <= w_ovf;
                    r_ready    <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready    = r_ready;
    assign overflow = r_overflow;

`ifdef HEX_DISPLAY_BLINK_EN
    localparam int c_blink_w = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [c_blink_w-1:0] r_blink_cnt;
    logic                 r_blink_on;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (r_blink_cnt == c_blink_w'(BLINK_DIV - 1)) begin
            r_blink_cnt <= '0;
            r_blink_on  <= ~r_blink_on;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    // Blanking only masks the output; stored digits are untouched.
    assign HEX_out = (blink_en && !r_blink_on) ? '1 : r_hex;
`else
    logic w_unused_blink;
    assign w_unused_blink = blink_en ^ (BLINK_DIV > 0);
    assign HEX_out        = r_hex;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hex_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_hex_display_ctrl
// Brief   : Self-checking bench: vector table, randomized loads against an
//           arithmetic reference model, and multi-cycle corner sequences.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hex_display_ctrl;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        load6 = 1'b0;
    logic        load4 = 1'b0;
    logic [15:0] data_in = '0;
    logic        mode = 1'b0;
    logic        blank_lz = 1'b0;
    logic        blink_en = 1'b0;
    logic        rdy6, rdy4, ovf6, ovf4;
    logic [47:0] hex6;
    logic [31:0] hex4;

    int n_pass  = 0;
    int n_total = 0;
    int k_cyc   = 0;

    logic [7:0] seg_tab [16];

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (Reset) k_cyc <= 0;
        else       k_cyc <= k_cyc + 1;
    end

    hex_display_ctrl #(.NUM_DIGITS(6), .DATA_W(16), .BLINK_DIV(4)) dut6 (
        .Clk(Clk), .Reset(Reset), .load(load6), .data_in(data_in), .mode(mode),
        .blank_lz(blank_lz), .blink_en(blink_en), .ready(rdy6), .overflow(ovf6),
        .HEX_out(hex6)
    );

    hex_display_ctrl #(.NUM_DIGITS(4), .DATA_W(16), .BLINK_DIV(4)) dut4 (
        .Clk(Clk), .Reset(Reset), .load(load4), .data_in(data_in), .mode(mode),
        .blank_lz(blank_lz), .blink_en(blink_en), .ready(rdy4), .overflow(ovf4),
        .HEX_out(hex4)
    );

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference: plain integer arithmetic over the display rules.
    function automatic logic [47:0] model(input logic [15:0] d, input logic m,
                                          input logic blz, input int nd, output logic ovf);
        int dig [6];
        int mag;
        int msd;
        logic neg;
        logic [47:0] r;
        r   = '1;
        ovf = 1'b0;
        neg = 1'b0;
        for (int i = 0; i < 6; i++) dig[i] = 0;
        if (!m) begin
            for (int i = 0; i < nd; i++) dig[i] = (i < 4) ? ((int'(d) >> (4 * i)) & 15) : 0;
        end else begin
            mag = int'($signed(d));
            neg = (mag < 0);
            if (neg) mag = -mag;
            for (int i = 0; i < nd - 1; i++) dig[i] = (mag / (10 ** i)) % 10;
            ovf = (mag >= 10 ** (nd - 1));
        end
        msd = 0;
        for (int i = 0; i < nd; i++) if (dig[i] != 0) msd = i;
        for (int i = 0; i < nd; i++) begin
            if (ovf)                  r[8*i +: 8] = 8'hBF;
            else if (m && i == nd-1)  r[8*i +: 8] = neg ? 8'hBF : 8'hFF;
            else if (blz && i > msd)  r[8*i +: 8] = 8'hFF;
            else                      r[8*i +: 8] = seg_tab[dig[i]];
        end
        return r;
    endfunction

    task automatic run_load(input bit use4, input logic [15:0] d, input logic m,
                            input logic b, output int low);
        @(negedge Clk);
        data_in = d; mode = m; blank_lz = b;
        if (use4) load4 = 1'b1; else load6 = 1'b1;
        @(negedge Clk);
        load4 = 1'b0; load6 = 1'b0;
        low = 0;
        while (((use4 ? rdy4 : rdy6) == 1'b0) && low < 100) begin
            low++;
            @(negedge Clk);
        end
    endtask

    typedef struct {
        logic [15:0] d;
        logic        m;
        logic        b;
        logic [47:0] exp;
        logic        ovf;
    } vec_t;

    vec_t vecs [7];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int low;
        logic eovf;
        logic [47:0] exp;
        logic [15:0] rd;
        logic rm, rb;
        logic [47:0] stored;
        bit ok;

        seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

        vecs[0] = '{16'h00AB, 1'b0, 1'b0, 48'hC0C0C0C08883, 1'b0};
        vecs[1] = '{16'hFB2E, 1'b1, 1'b1, 48'hBFFFF9A4B099, 1'b0};  // -1234
        vecs[2] = '{16'h8000, 1'b1, 1'b0, 48'hBFB0A4F88280, 1'b0};  // -32768
        vecs[3] = '{16'h1234, 1'b0, 1'b1, 48'hFFFFF9A4B099, 1'b0};
        vecs[4] = '{16'h0000, 1'b1, 1'b1, 48'hFFFFFFFFFFC0, 1'b0};
        vecs[5] = '{16'h7FFF, 1'b1, 1'b0, 48'hFFB0A4F882F8, 1'b0};  // 32767
        vecs[6] = '{16'hFFFF, 1'b0, 1'b1, 48'hFFFF8E8E8E8E, 1'b0};

        repeat (3) @(negedge Clk);
        check("reset_ready", {47'd0, rdy6}, 48'd1);
        check("reset_ovf", {47'd0, ovf6}, 48'd0);
        check("reset_hex", hex6, {48{1'b1}});
        check("reset_hex4", {16'd0, hex4}, {16'd0, 32'hFFFFFFFF});
        Reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_load(1'b0, vecs[i].d, vecs[i].m, vecs[i].b, low);
            check($sformatf("vec%0d_latency", i), 48'(low), vecs[i].m ? 48'd17 : 48'd1);
            check($sformatf("vec%0d_hex", i), hex6, vecs[i].exp);
            check($sformatf("vec%0d_ovf", i), {47'd0, ovf6}, {47'd0, vecs[i].ovf});
        end

        for (int i = 0; i < 30; i++) begin
            rd = 16'($urandom);
            rm = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            exp = model(rd, rm, rb, 6, eovf);
            run_load(1'b0, rd, rm, rb, low);
            check($sformatf("rand%0d_hex d=%h m=%0d b=%0d", i, rd, rm, rb), hex6, exp);
            check($sformatf("rand%0d_ovf", i), {47'd0, ovf6}, {47'd0, eovf});
            check($sformatf("rand%0d_latency", i), 48'(low), rm ? 48'd17 : 48'd1);
        end

        // Four-digit instance: overflow boundary.
        run_load(1'b1, 16'd999, 1'b1, 1'b0, low);
        check("d4_999_hex", {16'd0, hex4}, {16'd0, 32'hFF909090});
        check("d4_999_ovf", {47'd0, ovf4}, 48'd0);
        run_load(1'b1, 16'hFC19, 1'b1, 1'b0, low);  // -999
        check("d4_neg999_hex", {16'd0, hex4}, {16'd0, 32'hBF909090});
        run_load(1'b1, 16'd1000, 1'b1, 1'b0, low);
        check("d4_1000_ovf", {47'd0, ovf4}, 48'd1);
        run_load(1'b1, 16'd12345, 1'b1, 1'b0, low);
        check("d4_12345_hex", {16'd0, hex4}, {16'd0, 32'hBFBFBFBF});
        check("d4_12345_ovf", {47'd0, ovf4}, 48'd1);

        // Second load 5 cycles into a conversion is dropped.
        exp = model(16'd4321, 1'b1, 1'b0, 6, eovf);
        @(negedge Clk);
        data_in = 16'd4321; mode = 1'b1; blank_lz = 1'b0; load6 = 1'b1;
        @(negedge Clk);
        load6 = 1'b0;
        low = 0;
        while (!rdy6 && low < 100) begin
            low++;
            if (low == 5) begin data_in = 16'h00EE; mode = 1'b0; load6 = 1'b1; end
            else load6 = 1'b0;
            @(negedge Clk);
        end
        load6 = 1'b0;
        check("ignore_latency", 48'(low), 48'd17);
        check("ignore_hex", hex6, exp);
        ok = 1'b1;
        repeat (10) begin
            @(negedge Clk);
            if (!rdy6 || hex6 !== exp) ok = 1'b0;
        end
        check("ignore_no_requeue", {47'd0, ok}, 48'd1);

        // Reset at shift cycle 8, coincident with a load.
        @(negedge Clk);
        data_in = 16'hFB2E; mode = 1'b1; load6 = 1'b1;
        @(negedge Clk);
        load6 = 1'b0;
        repeat (7) @(negedge Clk);
        Reset = 1'b1; load6 = 1'b1;
        @(negedge Clk);
        Reset = 1'b0; load6 = 1'b0;
        check("abort_hex", hex6, {48{1'b1}});
        check("abort_ready", {47'd0, rdy6}, 48'd1);
        check("abort_ovf", {47'd0, ovf6}, 48'd0);
        check("abort_ovf4", {47'd0, ovf4}, 48'd0);
        ok = 1'b1;
        repeat (20) begin
            @(negedge Clk);
            if (!rdy6 || hex6 !== {48{1'b1}}) ok = 1'b0;
        end
        check("abort_stays_blank", {47'd0, ok}, 48'd1);

        run_load(1'b0, 16'h00AB, 1'b0, 1'b0, low);
        stored = 48'hC0C0C0C08883;
        check("blink_pre_hex", hex6, stored);
        @(negedge Clk);
        blink_en = 1'b1;
        for (int c = 0; c < 24; c++) begin
            #1;
`ifdef HEX_DISPLAY_BLINK_EN
            exp = (((k_cyc / 4) % 2) == 1) ? {48{1'b1}} : stored;
`else
            exp = stored;
`endif
            check($sformatf("blink_c%0d", c), hex6, exp);
            @(negedge Clk);
        end
        blink_en = 1'b0;
        #1;
        check("blink_restored", hex6, stored);
        check("blink_ready", {47'd0, rdy6}, 48'd1);
        check("blink_ovf", {47'd0, ovf6}, 48'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hex_display_ctrl.md
HEX_DISPLAY_CTRL -- requirements
Module: hex_display_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 6, number of seven-segment digits driven.
REQ-002 The block SHALL have parameter DATA_W, default 16, width of data_in.
REQ-003 The block SHALL have parameter BLINK_DIV, default 25_000_000, the number of clock cycles per blink half-period.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, with the following ports:
  Clk  in  1  system clock (50 MHz); all state on rising edge
  Reset  in  1  synchronous, active-high
  load  in  1  single-cycle strobe; accepted only when ready=1
  data_in  in  DATA_W  value to display; sampled on the accepted load
  mode  in  1  0 = hex unsigned, 1 = signed decimal; sampled with load
  blank_lz  in  1  1 = blank leading zeros; sampled with load
  blink_en  in  1  1 = blink the whole display
  ready  out  1  1 = idle, load accepted
  overflow  out  1  decimal magnitude does not fit in NUM_DIGITS-1 digits
  HEX_out  out  8*NUM_DIGITS  active-low segments; digit i = bits [8i+7:8i], bit 7 = DP (always 1)

Function
REQ-005 The FSM SHALL have states IDLE, SHIFT and DONE, with ready=1 only in IDLE.
REQ-006 In IDLE, load=1 SHALL capture data_in, mode and blank_lz, then go to DONE (mode 0) or SHIFT (mode 1).
REQ-007 SHIFT SHALL run sequential double-dabble, one bit per cycle, for exactly DATA_W cycles, then go to DONE.
REQ-008 DONE SHALL register all digits of HEX_out, and set overflow, in one edge, then return to IDLE; HEX_out SHALL never show a partially updated value.
REQ-009 Load-to-update latency SHALL be 1 cycle in hex mode and DATA_W+1 cycles in decimal mode, with ready rising on the same edge as the HEX_out update.
REQ-010 load while ready=0 SHALL be ignored, with no queueing.
REQ-011 In hex mode, digit i SHALL show nibble i of data_in, and digits at or above ceil(DATA_W/4) SHALL show '0'.
REQ-012 In decimal mode, the magnitude SHALL be the DATA_W+1-bit absolute value, so that the most negative input converts correctly.
REQ-013 In decimal mode, the magnitude SHALL occupy digits NUM_DIGITS-2..0.
REQ-014 In decimal mode, digit NUM_DIGITS-1 SHALL show '-' (8'hBF) when the input is negative, else blank.
REQ-015 When the magnitude is at least 10^(NUM_DIGITS-1), the block SHALL set overflow=1 and drive every digit to '-'; otherwise overflow=0.
REQ-016 With blank_lz=1, digits above the most significant non-zero digit SHALL be blank (8'hFF); digit 0 SHALL always be shown.
REQ-017 Segment encoding SHALL be HexDriver-compatible (0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E).

Reset
REQ-018 Reset SHALL force state=IDLE, ready=1, overflow=0, HEX_out all ones (blank), the blink counter to 0 and the blink phase to on.
REQ-019 Reset asserted mid-SHIFT SHALL abort the conversion, and HEX_out SHALL stay blank until the next completed load.
REQ-020 Reset SHALL dominate a coincident load.

Configuration
REQ-021 The macro HEX_DISPLAY_BLINK_EN SHALL control blinking: when defined, a free-running counter toggles the blink phase every BLINK_DIV cycles, and while blink_en=1 with phase off, HEX_out is forced to all ones.
REQ-022 Without HEX_DISPLAY_BLINK_EN, the counter SHALL be absent, blink_en SHALL be ignored and the display SHALL always be shown.
REQ-023 Toggling blink_en SHALL NOT alter ready, overflow or the stored digits.

Structure
REQ-024 A shared package hex_display_pkg SHALL hold the FSM state typedef, the segment constants SEG_BLANK=8'hFF and SEG_DASH=8'hBF, and the nibble-to-segment function.
REQ-025 The block SHALL instantiate one HexDriver per digit for nibble encoding, with the blank/dash override muxed after it; no other sub-modules.

Verification (NUM_DIGITS=6, DATA_W=16, BLINK_DIV=4)
REQ-026 Test 1 SHALL apply mode 0, data_in 16'h00AB, blank_lz=0 and require HEX_out digits 5..0 = C0,C0,C0,C0,88,83, with ready low for exactly 1 cycle.
REQ-027 Test 2 SHALL apply mode 1, data_in -1234, blank_lz=1 and require digits = BF,FF,F9,A4,B0,99, ready low for 17 cycles, and overflow=0.
REQ-028 Test 3 SHALL apply mode 1, data_in 16'h8000 and require digits = BF,B0,A4,F8,82,80 (-32768); with NUM_DIGITS=4 and data_in 12345, it SHALL require overflow=1 and all digits BF.
REQ-029 Test 4 SHALL pulse a second load 5 cycles after the first and require it to be ignored; Reset at SHIFT cycle 8 SHALL leave HEX_out all FF, ready=1 next cycle and overflow=0.
REQ-030 Test 5 (macro defined) SHALL set blink_en=1 and require HEX_out to alternate between stored digits and all FF every 4 cycles, with stored digits restored when blink_en=0.
REQ-031 Test 6 (macro undefined) SHALL set blink_en=1 and require HEX_out to remain constant.
